// File: rtl/fifo_rd_stream_if.sv
// Bundle of the FIFO read port, the downstream valid/ready stream and status outputs
// of fifo_rd_stream. The master modport is the adapter side, the slave modport is its environment.
interface fifo_rd_stream_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
);
  logic                  drain_en_i;
  logic                  fifo_empty_i;
  logic                  fifo_rden_o;
  logic [DATA_WIDTH-1:0] fifo_rdata_i;
  // Stream handshake: a beat transfers on every posedge where m_valid_o & m_ready_i;
  // m_valid_o never depends on m_ready_i and m_data_o holds while valid is stalled.
  logic                  m_valid_o;
  logic                  m_ready_i;
  logic [DATA_WIDTH-1:0] m_data_o;
  logic [CNT_WIDTH-1:0]  xfer_cnt_o;
  logic                  busy_o;
  logic [1:0]            occ_dbg;

  modport master (
    input  drain_en_i, fifo_empty_i, fifo_rdata_i, m_ready_i,
    output fifo_rden_o, m_valid_o, m_data_o, xfer_cnt_o, busy_o, occ_dbg
  );

  modport slave (
    output drain_en_i, fifo_empty_i, fifo_rdata_i, m_ready_i,
    input  fifo_rden_o, m_valid_o, m_data_o, xfer_cnt_o, busy_o, occ_dbg
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-side adapter: pops a synchronous FIFO (1-cycle read latency) into a 2-entry
// output buffer that feeds a valid/ready stream, and counts delivered beats.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  fifo_rd_stream_if.master   bus
);
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  occ_e                  r_occ;
  occ_e                  w_occ_next;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_rden;
  logic [2:0]            w_level;

  // State register: occupancy plus the read-in-flight flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_occ      <= OCC_EMPTY;
      r_inflight <= 1'b0;
    end else begin
      r_occ      <= w_occ_next;
      r_inflight <= w_rden;
    end
  end

  // Next-state logic.
  always_comb begin
    w_pop      = (r_occ != OCC_EMPTY) & bus.m_ready_i;
    w_push     = r_inflight;
    w_occ_next = r_occ;
    unique case ({w_push, w_pop})
      2'b10: w_occ_next = (r_occ == OCC_EMPTY) ? OCC_ONE : OCC_TWO;
      2'b01: w_occ_next = (r_occ == OCC_TWO) ? OCC_ONE : OCC_EMPTY;
      default: w_occ_next = r_occ;
    endcase
  end

  // Outputs. Words already buffered or in flight, minus the one leaving now, must leave
  // room for the word this pop returns next cycle.
  always_comb begin
    w_level         = 3'(r_occ) + 3'(r_inflight) - 3'(w_pop);
    w_rden          = rst_n & bus.drain_en_i & ~bus.fifo_empty_i & (w_level < 3'd2);
    bus.fifo_rden_o = w_rden;
    bus.m_valid_o   = (r_occ != OCC_EMPTY);
    bus.m_data_o    = r_head;
    bus.xfer_cnt_o  = r_cnt;
    bus.busy_o      = (r_occ != OCC_EMPTY) | r_inflight;
    bus.occ_dbg     = r_occ;
  end

  // Buffer datapath: head is the stream output, tail only holds a word when full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_pop) r_cnt <= r_cnt + 1'b1;
      unique case ({w_push, w_pop})
        2'b10: begin
          if (r_occ == OCC_EMPTY) r_head <= bus.fifo_rdata_i;
          else                    r_tail <= bus.fifo_rdata_i;
        end
        2'b01: begin
          if (r_occ == OCC_TWO) r_head <= r_tail;
        end
        2'b11: begin
          if (r_occ == OCC_TWO) begin
            r_head <= r_tail;
            r_tail <= bus.fifo_rdata_i;
          end else begin
            r_head <= bus.fifo_rdata_i;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
